// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind the UART receiver, with rts_n back-pressure, level IRQ and sticky overrun.
// Optional character-timeout logic is compiled in with `define UART_RX_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int RTS_THRESHOLD = 14,
  parameter int IRQ_LEVEL     = 1,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tick_i,
  input  logic                     wr_valid_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     wr_parity_err_i,
  input  logic                     wr_stop_err_i,
  input  logic                     rd_en_i,
  input  logic                     flush_i,
  output logic [7:0]               rd_data_o,
  output logic                     rd_parity_err_o,
  output logic                     rd_stop_err_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overrun_o,
  output logic                     rts_no,
  output logic                     rx_irq_o,
  output logic                     timeout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] RTS_C    = CW'(RTS_THRESHOLD);
  localparam logic [CW-1:0] IRQ_C    = CW'(IRQ_LEVEL);

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_empty, r_full, r_overrun, r_rts, r_irq;

  logic          w_wr_acc, w_rd_acc, w_timeout_next;
  logic [CW-1:0] w_count_next;

  // A full FIFO is never empty, so a simultaneous read always frees the slot the write needs.
  assign w_rd_acc = rd_en_i & ~r_empty & ~flush_i;
  assign w_wr_acc = wr_valid_i & (~r_full | w_rd_acc) & ~flush_i;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_count_next = r_count;
    if (flush_i)                   w_count_next = '0;
    else if (w_wr_acc && !w_rd_acc) w_count_next = r_count + CW'(1);
    else if (w_rd_acc && !w_wr_acc) w_count_next = r_count - CW'(1);
  end

  // NOTE: the storage array has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= {wr_stop_err_i, wr_parity_err_i, wr_data_i};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
      r_rts     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (flush_i) begin
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
        if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
        if (wr_valid_i && r_full && !rd_en_i) r_overrun <= 1'b1;
      end
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == DEPTH_C);
      r_rts   <= (w_count_next >= RTS_C);
      r_irq   <= (w_count_next >= IRQ_C) | w_timeout_next;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS) + 1;
  localparam logic [TW-1:0] TO_C = TW'(TIMEOUT_TICKS);

  logic [TW-1:0] r_idle, w_idle_next;
  logic          r_timeout, w_activity;

  assign w_activity = w_wr_acc | w_rd_acc | flush_i | (w_count_next == '0);

  always_comb begin
    w_idle_next = r_idle;
    if (w_activity)                    w_idle_next = '0;
    else if (tick_i && r_idle != TO_C) w_idle_next = r_idle + TW'(1);
  end

  assign w_timeout_next = w_activity ? 1'b0 : (r_timeout | (w_idle_next == TO_C));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_idle    <= w_idle_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_tick;
  assign w_unused_tick  = tick_i & (TIMEOUT_TICKS > 0);
  assign w_timeout_next = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  // Head entry is shown combinationally (FWFT) and masked to zero while empty.
  assign rd_data_o       = r_empty ? 8'h00 : r_mem[r_rptr][7:0];
  assign rd_parity_err_o = ~r_empty & r_mem[r_rptr][8];
  assign rd_stop_err_o   = ~r_empty & r_mem[r_rptr][9];
  assign empty_o         = r_empty;
  assign full_o          = r_full;
  assign count_o         = r_count;
  assign overrun_o       = r_overrun;
  assign rts_no          = r_rts;
  assign rx_irq_o        = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int RTS   = 14;
  localparam int IRQ   = 1;
  localparam int TO    = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick_i, wr_valid_i, wr_parity_err_i, wr_stop_err_i, rd_en_i, flush_i;
  logic [7:0] wr_data_i;
  logic [7:0] rd_data_o;
  logic       rd_parity_err_o, rd_stop_err_o, empty_o, full_o, overrun_o, rts_no, rx_irq_o, timeout_o;
  logic [4:0] count_o;

  uart_rx_fifo #(
    .DEPTH(DEPTH), .RTS_THRESHOLD(RTS), .IRQ_LEVEL(IRQ), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick_i(tick_i),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
    .wr_parity_err_i(wr_parity_err_i), .wr_stop_err_i(wr_stop_err_i),
    .rd_en_i(rd_en_i), .flush_i(flush_i),
    .rd_data_o(rd_data_o), .rd_parity_err_o(rd_parity_err_o), .rd_stop_err_o(rd_stop_err_o),
    .empty_o(empty_o), .full_o(full_o), .count_o(count_o), .overrun_o(overrun_o),
    .rts_no(rts_no), .rx_irq_o(rx_irq_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a plain queue of {stop, parity, data} plus sticky flags.
  logic [9:0] q[$];
  bit         m_ovr;
  bit         m_to;
  int         m_idle;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [9:0] head;
    head = (q.size() > 0) ? q[0] : 10'h000;
    check({tag, ".count"},   32'(count_o),         q.size());
    check({tag, ".empty"},   32'(empty_o),         32'(q.size() == 0));
    check({tag, ".full"},    32'(full_o),          32'(q.size() == DEPTH));
    check({tag, ".data"},    32'(rd_data_o),       32'(head[7:0]));
    check({tag, ".perr"},    32'(rd_parity_err_o), 32'(head[8]));
    check({tag, ".serr"},    32'(rd_stop_err_o),   32'(head[9]));
    check({tag, ".overrun"}, 32'(overrun_o),       32'(m_ovr));
    check({tag, ".rts_n"},   32'(rts_no),          32'(q.size() >= RTS));
    check({tag, ".irq"},     32'(rx_irq_o),        32'((q.size() >= IRQ) || m_to));
    check({tag, ".timeout"}, 32'(timeout_o),       32'(m_to));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr  = 1'b0;
    m_to   = 1'b0;
    m_idle = 0;
  endtask

  task automatic step(input string tag, input bit wv, input logic [7:0] wd, input bit pe,
                      input bit se, input bit re, input bit fl, input bit tk);
    int sz;
    bit rd_ok, wr_ok;
    wr_valid_i = wv; wr_data_i = wd; wr_parity_err_i = pe; wr_stop_err_i = se;
    rd_en_i = re; flush_i = fl; tick_i = tk;
    @(posedge clk);
    #1;
    wr_valid_i = 1'b0; rd_en_i = 1'b0; flush_i = 1'b0; tick_i = 1'b0;
    sz = q.size();
    if (fl) begin
      model_reset();
    end else begin
      rd_ok = re && sz > 0;
      wr_ok = wv && (sz < DEPTH || rd_ok);
      if (wv && sz == DEPTH && !re) m_ovr = 1'b1;
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back({se, pe, wd});
`ifdef UART_RX_TIMEOUT_EN
      if (wr_ok || rd_ok || q.size() == 0) begin
        m_idle = 0;
        m_to   = 1'b0;
      end else if (tk && m_idle < TO) begin
        m_idle++;
        if (m_idle == TO) m_to = 1'b1;
      end
`endif
    end
    check_all(tag);
  endtask

  task automatic wr(input string tag, input logic [7:0] d, input bit pe, input bit se);
    step(tag, 1'b1, d, pe, se, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input string tag);
    step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic flush(input string tag);
    step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    tick_i = 1'b0; wr_valid_i = 1'b0; wr_data_i = 8'h00; wr_parity_err_i = 1'b0;
    wr_stop_err_i = 1'b0; rd_en_i = 1'b0; flush_i = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;

    // Basic FWFT write/read with error flag.
    wr("wr41", 8'h41, 1'b0, 1'b0);
    wr("wr42", 8'h42, 1'b1, 1'b0);
    rd("rd41");
    rd("rd42");
    rd("rd_empty");

    // Overfill: 17 writes, the last is lost and sets overrun.
    for (int i = 0; i <= 16; i++) wr("fill17", 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) rd("drain17");

    // Simultaneous write+read while full.
    flush("flush_a");
    for (int i = 0; i < DEPTH; i++) wr("fill16", 8'(8'h20 + i), 1'b0, 1'(i & 1));
    step("full_wr_rd", 1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) rd("drain_aa");

    // Simultaneous write+read while empty.
    step("empty_wr_rd", 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rd("rd33");

    // RTS threshold crossing.
    for (int i = 0; i < RTS - 1; i++) wr("rts13", 8'(i), 1'b0, 1'b0);
    wr("rts14", 8'h0D, 1'b0, 1'b0);
    rd("rts_rd");

    // Flush with overrun set and a simultaneous write.
    flush("flush_b");
    for (int i = 0; i < DEPTH + 1; i++) wr("ovr_fill", 8'(8'h60 + i), 1'b0, 1'b0);
    step("flush_wr55", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("after_flush", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Character timeout (stays 0 when the feature is compiled out).
    wr("to_wr", 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < TO; i++) step("to_tick", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("to_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rd("to_rd");

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) wr("pre_rst", 8'(8'h90 + i), 1'b1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    reset_n = 1'b1;

    // Random traffic in write-heavy, read-heavy and balanced phases.
    for (int ph = 0; ph < 12; ph++) begin
      int wp, rp;
      wp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 25 : 50;
      rp = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 80 : 50;
      for (int i = 0; i < 200; i++) begin
        step("rand",
             $urandom_range(99) < wp, 8'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(99) < rp, $urandom_range(199) == 0, 1'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
